// File: rtl/writeback_forward.sv
// MIPS150 writeback register, load alignment, RegFile write port and operand bypass.
// Optional feature: define WB_BYPASS_EN to forward EX/WB results instead of stalling on them.
module writeback_forward #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic [2:0]        ex_load_type,
  input  logic [1:0]        ex_addr_lo,
  input  logic [4:0]        ex_rd,
  input  logic [DWIDTH-1:0] ex_alu_result,
  input  logic [DWIDTH-1:0] mem_dout,
  input  logic [4:0]        dec_ra1,
  input  logic [4:0]        dec_ra2,
  input  logic [DWIDTH-1:0] rf_rd1,
  input  logic [DWIDTH-1:0] rf_rd2,
  output logic [DWIDTH-1:0] op1,
  output logic [DWIDTH-1:0] op2,
  output logic              hazard,
  output logic              wb_we,
  output logic [4:0]        wb_wa,
  output logic [DWIDTH-1:0] wb_wd
);

  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic [2:0]        load_type_q, load_type_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [4:0]        rd_q, rd_d;
  logic [DWIDTH-1:0] alu_q, alu_d;

  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    load_type_d = load_type_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    if (!stall) begin
      valid_d     = ex_valid;
      regwrite_d  = ex_regwrite;
      memtoreg_d  = ex_memtoreg;
      load_type_d = ex_load_type;
      addr_lo_d   = ex_addr_lo;
      rd_d        = ex_rd;
      alu_d       = ex_alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      load_type_q <= 3'd0;
      addr_lo_q   <= 2'd0;
      rd_q        <= 5'd0;
      alu_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      load_type_q <= load_type_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
    end
  end

  // Big-endian lane select: offset 0 is the most significant byte.
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DWIDTH-1:0] ld_data;

  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = mem_dout[31:24];
      2'd1:    ld_byte = mem_dout[23:16];
      2'd2:    ld_byte = mem_dout[15:8];
      default: ld_byte = mem_dout[7:0];
    endcase
    ld_half = addr_lo_q[1] ? mem_dout[15:0] : mem_dout[31:16];
    case (load_type_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_dout;
    endcase
  end

  logic wb_qual;

  assign wb_qual = valid_q & regwrite_q & (rd_q != 5'd0);
  assign wb_we   = wb_qual & ~stall;
  assign wb_wa   = rd_q;
  assign wb_wd   = memtoreg_q ? ld_data : alu_q;

`ifdef WB_BYPASS_EN
  logic ex_fwd;
  logic ex_ld;

  assign ex_fwd = ex_valid & ex_regwrite & ~ex_memtoreg;
  assign ex_ld  = ex_valid & ex_regwrite & ex_memtoreg
                & (ex_rd != 5'd0);

  function automatic logic [DWIDTH-1:0] resolve(
    input logic [4:0]        ra,
    input logic [DWIDTH-1:0] rf
  );
    if (ra == 5'd0)
      resolve = '0;
    else if (ex_fwd && ex_rd == ra)
      resolve = ex_alu_result;
    else if (wb_qual && rd_q == ra)
      resolve = wb_wd;
    else
      resolve = rf;
  endfunction

  assign op1    = resolve(dec_ra1, rf_rd1);
  assign op2    = resolve(dec_ra2, rf_rd2);
  assign hazard = ex_ld & ((ex_rd == dec_ra1) | (ex_rd == dec_ra2));
`else
  logic ex_qual;
  logic hit1;
  logic hit2;

  assign ex_qual = ex_valid & ex_regwrite & (ex_rd != 5'd0);
  assign hit1    = (dec_ra1 != 5'd0)
                 & ((ex_qual & (ex_rd == dec_ra1))
                 |  (wb_qual & (rd_q == dec_ra1)));
  assign hit2    = (dec_ra2 != 5'd0)
                 & ((ex_qual & (ex_rd == dec_ra2))
                 |  (wb_qual & (rd_q == dec_ra2)));

  assign op1    = (dec_ra1 == 5'd0) ? '0 : rf_rd1;
  assign op2    = (dec_ra2 == 5'd0) ? '0 : rf_rd2;
  assign hazard = hit1 | hit2;
`endif

endmodule

// File: tb/tb_writeback_forward.sv
// Directed bench for writeback_forward; expectations follow the
// WB_BYPASS_EN setting the bench is compiled with.
module tb_writeback_forward;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        ex_valid, ex_regwrite, ex_memtoreg;
  logic [2:0]  ex_load_type;
  logic [1:0]  ex_addr_lo;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, mem_dout;
  logic [4:0]  dec_ra1, dec_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] op1, op2, wb_wd;
  logic        hazard, wb_we;
  logic [4:0]  wb_wa;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  writeback_forward #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_load_type(ex_load_type),
    .ex_addr_lo(ex_addr_lo), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .mem_dout(mem_dout),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .op1(op1), .op2(op2), .hazard(hazard),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ex_set(input logic v, input logic rw,
                        input logic ld, input logic [2:0] lt,
                        input logic [1:0] al, input logic [4:0] rd,
                        input logic [31:0] res);
    ex_valid = v; ex_regwrite = rw; ex_memtoreg = ld;
    ex_load_type = lt; ex_addr_lo = al; ex_rd = rd;
    ex_alu_result = res;
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  al;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t lv[10];

  initial begin
    lv[0] = '{3'b000, 2'd0, 32'hFFFFFF80};
    lv[1] = '{3'b000, 2'd1, 32'hFFFFFFF1};
    lv[2] = '{3'b000, 2'd2, 32'h0000007F};
    lv[3] = '{3'b000, 2'd3, 32'h00000002};
    lv[4] = '{3'b100, 2'd0, 32'h00000080};
    lv[5] = '{3'b001, 2'd0, 32'hFFFF80F1};
    lv[6] = '{3'b101, 2'd2, 32'h00007F02};
    lv[7] = '{3'b011, 2'd0, 32'h80F17F02};
    lv[8] = '{3'b001, 2'd3, 32'h00007F02};
    lv[9] = '{3'b111, 2'd1, 32'h80F17F02};

    rst = 1'b1; stall = 1'b0;
    ex_set(1'b1, 1'b1, 1'b0, 3'b011, 2'd0, 5'd5, 32'h55555555);
    mem_dout = 32'h0; dec_ra1 = 5'd0; dec_ra2 = 5'd0;
    rf_rd1 = 32'h0; rf_rd2 = 32'h0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_we", {31'd0, wb_we}, 32'd0);
      chk("rst_wd", wb_wd, 32'd0);
      chk("rst_wa", {27'd0, wb_wa}, 32'd0);
    end

    rst = 1'b0;
    ex_set(1'b1, 1'b1, 1'b0, 3'b011, 2'd0, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("alu_we", {31'd0, wb_we}, 32'd1);
    chk("alu_wa", {27'd0, wb_wa}, 32'd5);
    chk("alu_wd", wb_wd, 32'hDEADBEEF);
    ex_rd = 5'd0;
    @(negedge clk);
    chk("r0_we", {31'd0, wb_we}, 32'd0);

    mem_dout = 32'h80F17F02;
    for (int i = 0; i < 10; i++) begin
      ex_set(1'b1, 1'b1, 1'b1, lv[i].lt, lv[i].al, 5'd4, 32'h1000);
      @(negedge clk);
      chk($sformatf("load%0d", i), wb_wd, lv[i].exp);
    end

    ex_set(1'b1, 1'b1, 1'b0, 3'b011, 2'd0, 5'd3, 32'h22222222);
    @(negedge clk);
    ex_alu_result = 32'h11111111;
    dec_ra1 = 5'd3; dec_ra2 = 5'd0;
    rf_rd1 = 32'hAAAAAAAA; rf_rd2 = 32'hBBBBBBBB;
    #1;
    chk("fwd_ex", op1, BYP ? 32'h11111111 : 32'hAAAAAAAA);
    chk("fwd_r0", op2, 32'd0);
    chk("fwd_hz", {31'd0, hazard}, BYP ? 32'd0 : 32'd1);
    ex_valid = 1'b0;
    #1;
    chk("fwd_wb", op1, BYP ? 32'h22222222 : 32'hAAAAAAAA);
    chk("fwd_wb_hz", {31'd0, hazard}, BYP ? 32'd0 : 32'd1);
    dec_ra1 = 5'd12;
    #1;
    chk("fwd_rf", op1, 32'hAAAAAAAA);
    chk("nohit_hz", {31'd0, hazard}, 32'd0);

    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b1, 3'b011, 2'd0, 5'd7, 32'h2000);
    dec_ra1 = 5'd1; dec_ra2 = 5'd7;
    rf_rd2 = 32'h12345678;
    #1;
    chk("lu_hz", {31'd0, hazard}, 32'd1);
    @(negedge clk);
    ex_valid = 1'b0;
    mem_dout = 32'hCAFEF00D;
    #1;
    chk("lu_hz_wb", {31'd0, hazard}, BYP ? 32'd0 : 32'd1);
    chk("lu_op2", op2, BYP ? 32'hCAFEF00D : 32'h12345678);
    chk("lu_wd", wb_wd, 32'hCAFEF00D);

    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, 3'b011, 2'd0, 5'd9, 32'h99999999);
    dec_ra1 = 5'd0; dec_ra2 = 5'd0;
    @(negedge clk);
    stall = 1'b1;
    ex_set(1'b1, 1'b1, 1'b0, 3'b011, 2'd0, 5'd10, 32'hA0A0A0A0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_we", {31'd0, wb_we}, 32'd0);
      chk("stl_wa", {27'd0, wb_wa}, 32'd9);
      @(negedge clk);
    end
    stall = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("rel_we", {31'd0, wb_we}, 32'd1);
    chk("rel_wa", {27'd0, wb_wa}, 32'd9);
    chk("rel_wd", wb_wd, 32'h99999999);
    @(negedge clk);
    chk("rel_once", {31'd0, wb_we}, 32'd0);

    ex_set(1'b1, 1'b1, 1'b0, 3'b011, 2'd0, 5'd6, 32'h66666666);
    @(negedge clk);
    chk("pre_rst_we", {31'd0, wb_we}, 32'd1);
    rst = 1'b1; stall = 1'b1;
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, wb_we}, 32'd0);
    chk("mid_rst_wd", wb_wd, 32'd0);
    rst = 1'b0;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_we", {31'd0, wb_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
